vga_layer_arbiter: RTL and testbench
====================================

// Module: vga_layer_arbiter
// PURPOSE
//  Shares the single pixel_data input of the VGA driver among one background layer and up to
//  three rectangular overlay layers (sprites, text).
//  Each clock it takes the driver's pixel_x/pixel_y and the per-layer colours. It picks the
//  highest-priority enabled, covering, non-transparent layer and registers the result onto
//  pixel_data. Game logic writes window configuration at any time via a valid/ready port.
//  Configuration is shadowed and committed only at a frame boundary, so no frame ever tears.
// PARAMETERS
//  H_DISP      640     visible width; window right edge is clipped here
//  V_DISP      480     visible height; window bottom edge is clipped here
//  TRANSP_KEY  12'hF0F overlay colour treated as transparent (layer 0 is never transparent)
// PORTS
//  vga_clk      in   1   pixel clock, shared with the VGA driver
//  sys_rst_n    in   1   asynchronous reset, active-high
//  pixel_x      in   10  driver request x (0 outside the request window)
//  pixel_y      in   10  driver request y
//  vga_vs       in   1   driver field sync (low during the sync pulse)
//  layer0_rgb   in   12  background colour for (pixel_x,pixel_y), valid in the same cycle
//  layer1_rgb   in   12  overlay 1 colour, same timing
//  layer2_rgb   in   12  overlay 2 colour, same timing
//  layer3_rgb   in   12  overlay 3 colour, same timing (highest priority)
//  cfg_valid    in   1   configuration write request
//  cfg_ready    out  1   write accepted when cfg_valid && cfg_ready at posedge
//  cfg_layer    in   2   target layer 1..3; a write to 0 is accepted and discarded
//  cfg_en       in   1   window enable
//  cfg_x        in   10  window left
//  cfg_y        in   10  window top
//  cfg_w        in   10  window width (0 = empty)
//  cfg_h        in   10  window height (0 = empty)
//  pixel_data   out  12  arbitrated colour to the driver
//  layer_sel    out  2   layer index that produced pixel_data
//  commit_pulse out  1   one-cycle pulse when shadow config becomes active
//  frame_cnt    out  16  frame counter, +1 per frame boundary, wraps 16'hFFFF->0
// BEHAVIOUR
//  Reset (async, high): pixel_data=0, layer_sel=0, commit_pulse=0, frame_cnt=0, state=IDLE.
//   All active and pending windows are cleared (en=0, x=y=w=h=0), dirty bits are 0, and
//   vga_vs_d=1. Reset asserted mid-frame or mid-commit discards all pending writes.
//  Frame boundary (fb): vga_vs_d && !vga_vs, where vga_vs_d is vga_vs registered once.
//   Every fb increments frame_cnt.
//  FSM:
//   IDLE    -> PENDING when a write is accepted.
//   PENDING -> COMMIT when fb is seen (writes keep accumulating while in PENDING).
//   COMMIT  -> IDLE after one cycle.
//   In COMMIT: every layer with its dirty bit set copies pending to active, all dirty bits
//    clear, and commit_pulse=1.
//   fb in IDLE: no commit.
//  cfg_ready=1 in IDLE and PENDING, 0 in COMMIT.
//   A write accepted in the same cycle as fb is included in that commit.
//   Repeated writes to one layer before a commit: the last write wins.
//  Hit for layer k (k=1..3): en_k && x in [cfg_x, cfg_x+cfg_w) && y in [cfg_y, cfg_y+cfg_h).
//   Compute the bounds in 11 bits so there is no wrap, and also require x<H_DISP and y<V_DISP.
//  Selection priority is 3 > 2 > 1 > 0. Layer k wins only if it hits and layer_rgbk != TRANSP_KEY.
//   Layer 0 wins otherwise, even if layer0_rgb == TRANSP_KEY.
//  Latency: exactly 1 cycle. pixel_data and layer_sel are registered from the inputs of the
//   previous cycle, which lines up with the driver's one-cycle-early request.
//  Active config changes only in COMMIT, i.e. inside vertical blanking. Arbitration therefore
//   uses one config set for a whole frame.
// TESTING
//  1. Reset, no cfg, layer0=12'h123: pixel_data=12'h123 and layer_sel=0 one cycle after each
//     pixel_x; frame_cnt increments once per vga_vs falling edge.
//  2. Write L1 {en,x=100,y=50,w=20,h=10}, layer1=12'hF00 mid-frame. The current frame still
//     shows layer 0. Commit_pulse follows the next fb; from then on (100..119,50..59) gives
//     12'hF00/sel=1, and (120,50) and (100,60) give layer 0.
//  3. L1 and L3 both cover (10,10), layer3=TRANSP_KEY: output layer1, sel=1.
//     Set layer3=12'h0F0: output 12'h0F0, sel=3.
//  4. Window x=630,w=50: hits only for x 630..639. A write with cfg_layer=0 is accepted and
//     causes no state change.
//  5. Hold cfg_valid high across fb: cfg_ready drops only in the COMMIT cycle. The write
//     accepted in the fb cycle appears in the same commit; two writes to L2 leave the last one.
//  6. Assert reset while PENDING: pending is lost, there is no commit_pulse at the next fb,
//     and frame_cnt restarts at 0.

Source files
------------

// File: rtl/vga_layer_arbiter.sv
// Picks one of a background layer and three rectangular overlay layers per pixel for the VGA driver.
// Window configuration is shadowed and committed only at a frame boundary.
module vga_layer_arbiter #(
    parameter int          H_DISP     = 640,
    parameter int          V_DISP     = 480,
    parameter logic [11:0] TRANSP_KEY = 12'hF0F
) (
    input  logic        vga_clk,
    input  logic        sys_rst_n,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic        vga_vs,
    input  logic [11:0] layer0_rgb,
    input  logic [11:0] layer1_rgb,
    input  logic [11:0] layer2_rgb,
    input  logic [11:0] layer3_rgb,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [1:0]  cfg_layer,
    input  logic        cfg_en,
    input  logic [9:0]  cfg_x,
    input  logic [9:0]  cfg_y,
    input  logic [9:0]  cfg_w,
    input  logic [9:0]  cfg_h,
    output logic [11:0] pixel_data,
    output logic [1:0]  layer_sel,
    output logic        commit_pulse,
    output logic [15:0] frame_cnt
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PENDING = 2'd1;
    localparam logic [1:0] ST_COMMIT  = 2'd2;

    localparam logic [10:0] H_LIM = 11'(H_DISP);
    localparam logic [10:0] V_LIM = 11'(V_DISP);

    logic [1:0]  state_reg;
    logic [1:0]  state_next;
    logic        vs_d_reg;
    logic        fb;
    logic        accept;
    logic        cfg_write;
    logic [15:0] frame_cnt_reg;
    logic [11:0] pixel_data_reg;
    logic [11:0] pixel_data_next;
    logic [1:0]  layer_sel_reg;
    logic [1:0]  layer_sel_next;
    logic [3:1]  hit;
    logic [3:1]  opaque;
    logic [3:1]  win;
    logic [11:0] ov_rgb [1:3];
    logic        in_screen;

    assign fb           = vs_d_reg & ~vga_vs;
    assign cfg_ready    = (state_reg != ST_COMMIT);
    assign accept       = cfg_valid & cfg_ready;
    // Writes aimed at layer 0 are handshaken but otherwise ignored.
    assign cfg_write    = accept & (cfg_layer != 2'd0);
    assign commit_pulse = (state_reg == ST_COMMIT);

    assign ov_rgb[1] = layer1_rgb;
    assign ov_rgb[2] = layer2_rgb;
    assign ov_rgb[3] = layer3_rgb;

    assign in_screen = ({1'b0, pixel_x} < H_LIM) && ({1'b0, pixel_y} < V_LIM);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:    if (cfg_write) state_next = ST_PENDING;
            ST_PENDING: if (fb)        state_next = ST_COMMIT;
            ST_COMMIT:                 state_next = ST_IDLE;
            default:                   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge vga_clk or posedge sys_rst_n) begin
        if (sys_rst_n) begin
            state_reg     <= ST_IDLE;
            vs_d_reg      <= 1'b1;
            frame_cnt_reg <= 16'd0;
        end else begin
            state_reg <= state_next;
            vs_d_reg  <= vga_vs;
            if (fb)
                frame_cnt_reg <= frame_cnt_reg + 16'd1;
        end
    end

    genvar gi;
    generate
        for (gi = 1; gi <= 3; gi++) begin : g_layer
            logic        pend_en_reg;
            logic [9:0]  pend_x_reg;
            logic [9:0]  pend_y_reg;
            logic [9:0]  pend_w_reg;
            logic [9:0]  pend_h_reg;
            logic        dirty_reg;
            logic        act_en_reg;
            logic [9:0]  act_x_reg;
            logic [9:0]  act_y_reg;
            logic [9:0]  act_w_reg;
            logic [9:0]  act_h_reg;
            logic [10:0] x_end;
            logic [10:0] y_end;

            always_ff @(posedge vga_clk or posedge sys_rst_n) begin
                if (sys_rst_n) begin
                    pend_en_reg <= 1'b0;
                    pend_x_reg  <= 10'd0;
                    pend_y_reg  <= 10'd0;
                    pend_w_reg  <= 10'd0;
                    pend_h_reg  <= 10'd0;
                    dirty_reg   <= 1'b0;
                    act_en_reg  <= 1'b0;
                    act_x_reg   <= 10'd0;
                    act_y_reg   <= 10'd0;
                    act_w_reg   <= 10'd0;
                    act_h_reg   <= 10'd0;
                end else if (state_reg == ST_COMMIT) begin
                    // No write can land here: cfg_ready is low during COMMIT.
                    if (dirty_reg) begin
                        act_en_reg <= pend_en_reg;
                        act_x_reg  <= pend_x_reg;
                        act_y_reg  <= pend_y_reg;
                        act_w_reg  <= pend_w_reg;
                        act_h_reg  <= pend_h_reg;
                    end
                    dirty_reg <= 1'b0;
                end else if (cfg_write && (cfg_layer == 2'(gi))) begin
                    pend_en_reg <= cfg_en;
                    pend_x_reg  <= cfg_x;
                    pend_y_reg  <= cfg_y;
                    pend_w_reg  <= cfg_w;
                    pend_h_reg  <= cfg_h;
                    dirty_reg   <= 1'b1;
                end
            end

            // 11-bit right/bottom edges so a window hanging past 1023 cannot wrap.
            assign x_end = {1'b0, act_x_reg} + {1'b0, act_w_reg};
            assign y_end = {1'b0, act_y_reg} + {1'b0, act_h_reg};

            assign hit[gi] = act_en_reg && in_screen &&
                             (pixel_x >= act_x_reg) && ({1'b0, pixel_x} < x_end) &&
                             (pixel_y >= act_y_reg) && ({1'b0, pixel_y} < y_end);
            assign opaque[gi] = (ov_rgb[gi] != TRANSP_KEY);
        end
    endgenerate

    assign win = hit & opaque;

    always_comb begin
        pixel_data_next = layer0_rgb;
        layer_sel_next  = 2'd0;
        if (win[3]) begin
            pixel_data_next = layer3_rgb;
            layer_sel_next  = 2'd3;
        end else if (win[2]) begin
            pixel_data_next = layer2_rgb;
            layer_sel_next  = 2'd2;
        end else if (win[1]) begin
            pixel_data_next = layer1_rgb;
            layer_sel_next  = 2'd1;
        end
    end

    always_ff @(posedge vga_clk or posedge sys_rst_n) begin
        if (sys_rst_n) begin
            pixel_data_reg <= 12'd0;
            layer_sel_reg  <= 2'd0;
        end else begin
            pixel_data_reg <= pixel_data_next;
            layer_sel_reg  <= layer_sel_next;
        end
    end

    assign pixel_data = pixel_data_reg;
    assign layer_sel  = layer_sel_reg;
    assign frame_cnt  = frame_cnt_reg;

endmodule

// File: tb/tb_vga_layer_arbiter.sv
// Scoreboard bench for vga_layer_arbiter: a behavioural model predicts each pixel,
// the prediction is queued on drive and compared when the registered output appears.
module tb_vga_layer_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  px, py;
    logic        vs;
    logic [11:0] l0, l1, l2, l3;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_layer;
    logic        cfg_en;
    logic [9:0]  cfg_x, cfg_y, cfg_w, cfg_h;
    logic [11:0] pixel_data;
    logic [1:0]  layer_sel;
    logic        commit_pulse;
    logic [15:0] frame_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vga_layer_arbiter dut (
        .vga_clk     (clk),
        .sys_rst_n   (rst),
        .pixel_x     (px),
        .pixel_y     (py),
        .vga_vs      (vs),
        .layer0_rgb  (l0),
        .layer1_rgb  (l1),
        .layer2_rgb  (l2),
        .layer3_rgb  (l3),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_layer   (cfg_layer),
        .cfg_en      (cfg_en),
        .cfg_x       (cfg_x),
        .cfg_y       (cfg_y),
        .cfg_w       (cfg_w),
        .cfg_h       (cfg_h),
        .pixel_data  (pixel_data),
        .layer_sel   (layer_sel),
        .commit_pulse(commit_pulse),
        .frame_cnt   (frame_cnt)
    );

    // Reference model state
    int   m_state;
    bit   m_vs_d;
    int   m_frame;
    bit   m_dirty [1:3];
    bit   m_pen   [1:3];
    int   m_px [1:3], m_py [1:3], m_pw [1:3], m_ph [1:3];
    bit   m_aen   [1:3];
    int   m_ax [1:3], m_ay [1:3], m_aw [1:3], m_ah [1:3];
    logic [13:0] exp_q [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_vs_d  = 1'b1;
        m_frame = 0;
        for (int k = 1; k <= 3; k++) begin
            m_dirty[k] = 0; m_pen[k] = 0; m_aen[k] = 0;
            m_px[k] = 0; m_py[k] = 0; m_pw[k] = 0; m_ph[k] = 0;
            m_ax[k] = 0; m_ay[k] = 0; m_aw[k] = 0; m_ah[k] = 0;
        end
        exp_q.delete();
    endtask

    function automatic bit m_hit(input int k, input int x, input int y);
        return m_aen[k] && x < 640 && y < 480 &&
               x >= m_ax[k] && x < m_ax[k] + m_aw[k] &&
               y >= m_ay[k] && y < m_ay[k] + m_ah[k];
    endfunction

    function automatic logic [13:0] m_pixel();
        logic [11:0] rgb [1:3];
        logic [13:0] r;
        rgb[1] = l1; rgb[2] = l2; rgb[3] = l3;
        r = {2'd0, l0};
        for (int k = 1; k <= 3; k++)
            if (m_hit(k, int'(px), int'(py)) && rgb[k] != 12'hF0F)
                r = {2'(k), rgb[k]};
        return r;
    endfunction

    // One pixel clock: inputs are already set (after a negedge); returns at the next negedge.
    task automatic tick();
        logic [13:0] e;
        bit fb, acc;
        check_eq("cfg_ready", cfg_ready, (m_state != 2));
        check_eq("commit_pulse", commit_pulse, (m_state == 2));
        exp_q.push_back(m_pixel());
        fb  = m_vs_d && !vs;
        acc = cfg_valid && (m_state != 2);
        if (fb) m_frame = (m_frame + 1) % 65536;
        case (m_state)
            0: if (acc && cfg_layer != 0) m_state = 1;
            1: if (fb) m_state = 2;
            default: begin
                for (int k = 1; k <= 3; k++) begin
                    if (m_dirty[k]) begin
                        m_aen[k] = m_pen[k]; m_ax[k] = m_px[k]; m_ay[k] = m_py[k];
                        m_aw[k] = m_pw[k]; m_ah[k] = m_ph[k];
                    end
                    m_dirty[k] = 0;
                end
                m_state = 0;
            end
        endcase
        if (acc && cfg_layer != 0) begin
            m_pen[cfg_layer] = cfg_en; m_px[cfg_layer] = cfg_x; m_py[cfg_layer] = cfg_y;
            m_pw[cfg_layer] = cfg_w; m_ph[cfg_layer] = cfg_h; m_dirty[cfg_layer] = 1;
        end
        m_vs_d = vs;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check_eq("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check_eq("pixel_data", pixel_data, e[11:0]);
            check_eq("layer_sel", layer_sel, e[13:12]);
        end
        check_eq("frame_cnt", frame_cnt, m_frame);
        @(negedge clk);
    endtask

    task automatic write_cfg(input logic [1:0] lay, input logic en,
                             input int x, input int y, input int w, input int h);
        cfg_valid = 1'b1; cfg_layer = lay; cfg_en = en;
        cfg_x = 10'(x); cfg_y = 10'(y); cfg_w = 10'(w); cfg_h = 10'(h);
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic vsync();
        vs = 1'b0; tick(); tick();
        vs = 1'b1; tick();
    endtask

    task automatic scan(input int x0, input int y, input int n);
        for (int i = 0; i < n; i++) begin
            px = 10'(x0 + i); py = 10'(y);
            tick();
        end
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        check_eq("rst_pixel_data", pixel_data, 12'd0);
        check_eq("rst_layer_sel", layer_sel, 2'd0);
        check_eq("rst_frame_cnt", frame_cnt, 16'd0);
        check_eq("rst_commit_pulse", commit_pulse, 1'b0);
        check_eq("rst_cfg_ready", cfg_ready, 1'b1);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0; vs = 1'b1; px = '0; py = '0;
        l0 = 12'h123; l1 = 12'hF00; l2 = 12'h00F; l3 = 12'h0F0;
        cfg_valid = 1'b0; cfg_layer = '0; cfg_en = 1'b0;
        cfg_x = '0; cfg_y = '0; cfg_w = '0; cfg_h = '0;
        @(negedge clk);
        do_reset();

        // 1: background only, frame counting
        scan(0, 0, 8);
        vsync();
        check_eq("t1_frame", frame_cnt, 16'd1);

        // 2: L1 written mid-frame, visible only after the commit
        write_cfg(2'd1, 1'b1, 100, 50, 20, 10);
        scan(98, 50, 24);
        check_eq("t2_before_commit", layer_sel, 2'd0);
        vsync();
        scan(95, 50, 30);
        scan(100, 59, 2);
        check_eq("t2_in_window", pixel_data, 12'hF00);
        scan(120, 50, 1);
        check_eq("t2_right_edge", pixel_data, 12'h123);
        scan(100, 60, 1);
        check_eq("t2_bottom_edge", layer_sel, 2'd0);

        // 3: overlapping L1/L3, transparent key on top layer
        write_cfg(2'd1, 1'b1, 0, 0, 200, 100);
        write_cfg(2'd3, 1'b1, 0, 0, 20, 20);
        vsync();
        l3 = 12'hF0F;
        scan(8, 10, 4);
        check_eq("t3_transp_sel", layer_sel, 2'd1);
        l3 = 12'h0F0;
        scan(8, 10, 4);
        check_eq("t3_opaque_sel", layer_sel, 2'd3);

        // 4: right-edge clipping, and a discarded write to layer 0
        write_cfg(2'd2, 1'b1, 630, 0, 50, 480);
        vsync();
        write_cfg(2'd0, 1'b1, 1, 2, 3, 4);
        vsync();
        scan(625, 5, 20);
        scan(639, 5, 1);
        check_eq("t4_x639", layer_sel, 2'd2);
        scan(640, 5, 1);
        check_eq("t4_x640", layer_sel, 2'd0);

        // 5: cfg_valid held across the frame boundary, last write to L2 wins
        cfg_valid = 1'b1; cfg_layer = 2'd2; cfg_en = 1'b1;
        cfg_x = 10'd10; cfg_y = 10'd10; cfg_w = 10'd5; cfg_h = 10'd5;
        tick();
        cfg_x = 10'd300; cfg_y = 10'd200; cfg_w = 10'd10; cfg_h = 10'd10;
        vs = 1'b0;
        tick();
        tick();
        vs = 1'b1;
        tick();
        cfg_valid = 1'b0;
        scan(298, 200, 4);
        scan(305, 205, 1);
        check_eq("t5_last_write", layer_sel, 2'd2);
        vsync();

        // 6: reset while pending drops the write and restarts the frame count
        write_cfg(2'd1, 1'b0, 0, 0, 0, 0);
        scan(50, 20, 3);
        do_reset();
        vsync();
        check_eq("t6_frame_restart", frame_cnt, 16'd1);
        scan(50, 20, 2);
        check_eq("t6_no_windows", layer_sel, 2'd0);

        // Random pixels over a fresh window set
        write_cfg(2'd1, 1'b1, 0, 0, 300, 300);
        write_cfg(2'd2, 1'b1, 200, 100, 400, 300);
        write_cfg(2'd3, 1'b1, 500, 400, 200, 200);
        vsync();
        for (int i = 0; i < 300; i++) begin
            px = 10'($urandom_range(0, 700));
            py = 10'($urandom_range(0, 520));
            l0 = 12'($urandom);
            l1 = ($urandom_range(0, 3) == 0) ? 12'hF0F : 12'($urandom);
            l2 = ($urandom_range(0, 3) == 0) ? 12'hF0F : 12'($urandom);
            l3 = ($urandom_range(0, 3) == 0) ? 12'hF0F : 12'($urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
